// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM fader: colour indices, PWM width,
// channel map and the fade state encoding.
package led_pkg;
  localparam int PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] LVL_MAX = 8'hFF;

  localparam int NUM_LED = 8;
  localparam int NUM_CH  = 11;
  localparam int CH_R    = 8;
  localparam int CH_G    = 9;
  localparam int CH_B    = 10;

  typedef enum logic [1:0] {
    WHITE = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_FADING = 1'b1
  } fade_state_e;

  // Which RGB channels are lit for a colour, packed as {b, g, r}.
  function automatic logic [2:0] rgb_mask(input color_e c);
    case (c)
      WHITE:   rgb_mask = 3'b111;
      RED:     rgb_mask = 3'b001;
      GREEN:   rgb_mask = 3'b010;
      default: rgb_mask = 3'b100;
    endcase
  endfunction
endpackage

// File: rtl/led_fade_chan.sv
// One fade channel: 8-bit level stepping toward its target on each tick,
// PWM compare against the shared counter, and the registered output driver.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int STEP       = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] target_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [PWM_BITS-1:0] level_nxt_o,
  output logic                pwm_o
);
  localparam logic [PWM_BITS-1:0] STEP_W = PWM_BITS'(STEP);

  logic [PWM_BITS-1:0] level_q, level_d, gap;
  logic                ch_on, pwm_d, pwm_q;

  // Clamp when the remaining gap fits in one step, so the level never overshoots or wraps.
  always_comb begin
    level_d = level_q;
    gap     = '0;
    if (tick_i) begin
      if (level_q < target_i) begin
        gap     = target_i - level_q;
        level_d = (gap <= STEP_W) ? target_i : level_q + STEP_W;
      end else if (level_q > target_i) begin
        gap     = level_q - target_i;
        level_d = (gap <= STEP_W) ? target_i : level_q - STEP_W;
      end
    end
  end

  // Full scale is forced: the compare alone could only reach 255 of 256 cycles.
  assign ch_on = (level_q == LVL_MAX) || (pwm_cnt_i < level_q);
  assign pwm_d = ch_on ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      pwm_q   <= ACTIVE_LOW;
    end else begin
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  assign level_nxt_o = level_d;
  assign pwm_o       = pwm_q;
endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader: one-deep pattern holding register, fade tick divider and
// eleven fading PWM channels (8 LEDs + RGB) with a two-state busy tracker.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pat_valid,
  output logic       pat_ready,
  input  logic [7:0] pat_data,
  input  logic [1:0] color_in,
  output logic [7:0] led_n,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b,
  output logic       busy
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]                     tick_cnt_q, tick_cnt_d;
  logic                              tick, accept, any_diff;
  logic [PWM_BITS-1:0]               pwm_cnt_q;
  logic                              pending_q, pending_d;
  logic [7:0]                        hold_data_q;
  color_e                            hold_color_q;
  logic [2:0]                        rgb_tgt;
  logic [NUM_CH-1:0][PWM_BITS-1:0]   target_q, target_d, level_nxt;
  logic [NUM_CH-1:0]                 pwm_out;
  fade_state_e                       state_q, state_d;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign accept     = pat_valid && !pending_q;
  assign pat_ready  = !pending_q;
  assign rgb_tgt    = rgb_mask(hold_color_q);

  // An accept only happens with pending clear, so it always wins over the tick clear.
  always_comb begin
    pending_d = pending_q;
    if (tick)   pending_d = 1'b0;
    if (accept) pending_d = 1'b1;
  end

  always_comb begin
    target_d = target_q;
    if (tick && pending_q) begin
      for (int i = 0; i < NUM_LED; i++)
        target_d[i] = hold_data_q[i] ? LVL_MAX : '0;
      target_d[CH_R] = rgb_tgt[0] ? LVL_MAX : '0;
      target_d[CH_G] = rgb_tgt[1] ? LVL_MAX : '0;
      target_d[CH_B] = rgb_tgt[2] ? LVL_MAX : '0;
    end
  end

  // Levels step against the old targets, so comparing next levels with next
  // targets covers both a fresh load and the final clamping step.
  assign any_diff = (level_nxt != target_d);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_diff)  state_d = S_FADING;
      S_FADING: if (!any_diff) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      pwm_cnt_q    <= '0;
      pending_q    <= 1'b0;
      hold_data_q  <= '0;
      hold_color_q <= WHITE;
      target_q     <= '0;
      state_q      <= S_IDLE;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      pending_q  <= pending_d;
      if (accept) begin
        hold_data_q  <= pat_data;
        hold_color_q <= color_e'(color_in);
      end
      target_q <= target_d;
      state_q  <= state_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_fade_chan #(
      .STEP       (STEP),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .target_i    (target_q[g]),
      .pwm_cnt_i   (pwm_cnt_q),
      .level_nxt_o (level_nxt[g]),
      .pwm_o       (pwm_out[g])
    );
  end

  assign led_n = pwm_out[NUM_LED-1:0];
  assign rgb_r = pwm_out[CH_R];
  assign rgb_g = pwm_out[CH_G];
  assign rgb_b = pwm_out[CH_B];
  assign busy  = (state_q == S_FADING) || pending_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader (TICK_DIV=4, STEP=64, active-low),
// compared cycle by cycle against a behavioural fade model.
module tb_led_pwm_fader;
  localparam int TDIV = 4;
  localparam int STP  = 64;

  logic       clk, rst, pat_valid, pat_ready, busy, rgb_r, rgb_g, rgb_b;
  logic [7:0] pat_data, led_n;
  logic [1:0] color_in;
  // slow-tick instance used to hold a level long enough to measure duty
  logic       p2_valid, p2_ready, p2_busy, p2_r, p2_g, p2_b;
  logic [7:0] p2_data, p2_led;
  logic [1:0] p2_color;
  logic [7:0] lvl0;

  int total = 0;
  int bad   = 0;

  led_pwm_fader #(.TICK_DIV(TDIV), .STEP(STP), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .color_in(color_in), .led_n(led_n),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .busy(busy));

  led_pwm_fader #(.TICK_DIV(1000), .STEP(STP), .ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .pat_valid(p2_valid), .pat_ready(p2_ready),
    .pat_data(p2_data), .color_in(p2_color), .led_n(p2_led),
    .rgb_r(p2_r), .rgb_g(p2_g), .rgb_b(p2_b), .busy(p2_busy));

  assign lvl0 = dut.g_ch[0].u_ch.level_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int          m_cyc = 0;
  int          m_lvl[11];
  int          m_tgt[11];
  bit          m_pend = 0, m_pend0 = 0, m_tick = 0, m_busy = 0;
  logic [7:0]  m_hdata = '0;
  logic [1:0]  m_hcol = '0;
  logic [10:0] m_out = '1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_pend = 0; m_hdata = '0; m_hcol = '0; m_out = '1; m_busy = 0;
      for (int i = 0; i < 11; i++) begin m_lvl[i] = 0; m_tgt[i] = 0; end
    end else begin
      m_tick  = (m_cyc % TDIV) == TDIV - 1;
      m_pend0 = m_pend;
      for (int i = 0; i < 11; i++)
        m_out[i] = !(m_lvl[i] == 255 || (m_cyc % 256) < m_lvl[i]);
      if (m_tick) begin
        for (int i = 0; i < 11; i++) begin
          if (m_tgt[i] > m_lvl[i])      m_lvl[i] = (m_lvl[i] + STP > m_tgt[i]) ? m_tgt[i] : m_lvl[i] + STP;
          else if (m_tgt[i] < m_lvl[i]) m_lvl[i] = (m_lvl[i] - STP < m_tgt[i]) ? m_tgt[i] : m_lvl[i] - STP;
        end
        if (m_pend0) begin
          for (int i = 0; i < 8; i++) m_tgt[i] = m_hdata[i] ? 255 : 0;
          m_tgt[8]  = (m_hcol == 0 || m_hcol == 1) ? 255 : 0;
          m_tgt[9]  = (m_hcol == 0 || m_hcol == 2) ? 255 : 0;
          m_tgt[10] = (m_hcol == 0 || m_hcol == 3) ? 255 : 0;
          m_pend = 0;
        end
      end
      if (pat_valid && !m_pend0) begin
        m_pend = 1; m_hdata = pat_data; m_hcol = color_in;
      end
      m_busy = m_pend;
      for (int i = 0; i < 11; i++) if (m_lvl[i] != m_tgt[i]) m_busy = 1;
      m_cyc++;
    end
  end

  // Drive a pattern and hold it until the fader has taken it.
  task automatic send(input logic [7:0] d, input logic [1:0] c);
    int n = 0;
    @(negedge clk);
    pat_valid = 1'b1; pat_data = d; color_in = c;
    while (!pat_ready && n < 50) begin @(negedge clk); n++; end
    total++;
    if (!pat_ready) begin bad++; $display("FAIL send_timeout: pat_ready=%b want 1", pat_ready); end
    @(negedge clk);
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pat_valid = 0; pat_data = '0; color_in = '0;
    p2_valid = 0; p2_data = '0; p2_color = '0;
    #1 rst = 1'b1;
    #1;
    total++; if (led_n !== 8'hFF) begin bad++; $display("FAIL reset_led: got %h want ff", led_n); end
    total++; if ({rgb_r, rgb_g, rgb_b} !== 3'b111) begin bad++; $display("FAIL reset_rgb: got %b want 111", {rgb_r, rgb_g, rgb_b}); end
    total++; if (pat_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", pat_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_duty();
    int n = 0, zeros = 0;
    @(negedge clk);
    p2_valid = 1'b1; p2_data = 8'h01; p2_color = 2'd0;
    @(negedge clk);
    p2_valid = 1'b0;
    while (p2_led[0] !== 1'b0 && n < 2500) begin @(negedge clk); n++; end
    total++; if (p2_led[0] !== 1'b0) begin bad++; $display("FAIL duty_start: led0=%b want 0", p2_led[0]); end
    for (int c = 0; c < 256; c++) begin
      if (p2_led[0] === 1'b0) zeros++;
      @(negedge clk);
    end
    total++; if (zeros != 64) begin bad++; $display("FAIL duty_64: on cycles=%0d want 64", zeros); end
  endtask

  task automatic test_fade_up();
    int seen[$];
    int exp_seq[4] = '{64, 128, 192, 255};
    int prev = 0;
    send(8'h01, 2'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== m_out) begin bad++; $display("FAIL up_out: got %h want %h", {rgb_b, rgb_g, rgb_r, led_n}, m_out); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL up_busy: got %b want %b", busy, m_busy); end
      total++; if ({rgb_g, rgb_b} !== 2'b11) begin bad++; $display("FAIL up_gb: got %b want 11", {rgb_g, rgb_b}); end
      if (int'(lvl0) != prev) begin
        seen.push_back(int'(lvl0)); prev = int'(lvl0);
        if (lvl0 == 8'hFF) begin
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL up_busy_drop: got %b want 0", busy); end
        end
      end
    end
    total++;
    if (seen.size() != 4) begin bad++; $display("FAIL up_seq_len: got %0d want 4", seen.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (seen[i] != exp_seq[i]) begin bad++; $display("FAIL up_seq[%0d]: got %0d want %0d", i, seen[i], exp_seq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int phase = 0, hi = 0, lo = 0;
    bit acc = 0;
    @(negedge clk);
    pat_valid = 1'b1; pat_data = 8'hF0; color_in = 2'd2;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      total++; if (pat_ready !== !m_pend) begin bad++; $display("FAIL b2b_ready: got %b want %b", pat_ready, !m_pend); end
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== m_out) begin bad++; $display("FAIL b2b_out: got %h want %h", {rgb_b, rgb_g, rgb_r, led_n}, m_out); end
      if (acc) begin
        if (phase == 0) begin phase = 1; pat_data = 8'h0F; color_in = 2'd3; end
        else if (phase == 1) begin phase = 2; pat_valid = 1'b0; end
      end
      if (phase == 1) begin if (pat_ready) hi++; else lo++; end
      acc = pat_valid && pat_ready;
    end
    total++; if (phase != 2) begin bad++; $display("FAIL b2b_done: phase=%0d want 2", phase); end
    total++; if (hi != 1 || lo < 1) begin bad++; $display("FAIL b2b_stall: ready-high=%0d ready-low=%0d want 1 and >=1", hi, lo); end
  endtask

  task automatic test_reverse();
    int seen[$];
    int exp_seq[3] = '{128, 64, 0};
    int n = 0, prev = 64;
    send(8'h00, 2'd1);
    while (busy && n < 80) begin @(negedge clk); n++; end
    send(8'h01, 2'd1);
    n = 0;
    while (lvl0 != 8'd64 && n < 80) begin
      @(negedge clk); n++;
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== m_out) begin bad++; $display("FAIL rev_out: got %h want %h", {rgb_b, rgb_g, rgb_r, led_n}, m_out); end
    end
    total++; if (lvl0 !== 8'd64) begin bad++; $display("FAIL rev_reach64: got %0d want 64", lvl0); end
    send(8'h00, 2'd1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++; if (int'(lvl0) != m_lvl[0]) begin bad++; $display("FAIL rev_level: got %0d want %0d", lvl0, m_lvl[0]); end
      if (int'(lvl0) != prev) begin seen.push_back(int'(lvl0)); prev = int'(lvl0); end
    end
    total++;
    if (seen.size() != 3) begin bad++; $display("FAIL rev_seq_len: got %0d want 3", seen.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (seen[i] != exp_seq[i]) begin bad++; $display("FAIL rev_seq[%0d]: got %0d want %0d", i, seen[i], exp_seq[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(8'hFF, 2'd2);
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== 11'h7FF) begin bad++; $display("FAIL mid_rst_out: got %h want 7ff", {rgb_b, rgb_g, rgb_r, led_n}); end
    total++; if (busy !== 1'b0 || pat_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_flags: busy=%b ready=%b want 0 1", busy, pat_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== 11'h7FF) begin bad++; $display("FAIL post_rst_out: got %h want 7ff", {rgb_b, rgb_g, rgb_r, led_n}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    end
    send(8'h01, 2'd0);
    while (led_n[0] !== 1'b0 && n < 40) begin
      @(negedge clk); n++;
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== m_out) begin bad++; $display("FAIL post_rst_fade: got %h want %h", {rgb_b, rgb_g, rgb_r, led_n}, m_out); end
    end
    total++; if (led_n[0] !== 1'b0) begin bad++; $display("FAIL post_rst_on: led0=%b want 0", led_n[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++; if ({rgb_b, rgb_g, rgb_r, led_n} !== m_out) begin bad++; $display("FAIL rnd_out: got %h want %h", {rgb_b, rgb_g, rgb_r, led_n}, m_out); end
      total++; if (busy !== m_busy || pat_ready !== !m_pend) begin bad++; $display("FAIL rnd_flags: busy=%b ready=%b want %b %b", busy, pat_ready, m_busy, !m_pend); end
      total++; if (int'(lvl0) != m_lvl[0]) begin bad++; $display("FAIL rnd_level: got %0d want %0d", lvl0, m_lvl[0]); end
      if (!(pat_valid && !pat_ready)) begin
        pat_valid = ($urandom_range(0, 5) == 0);
        pat_data  = 8'($urandom);
        color_in  = 2'($urandom);
      end
    end
    pat_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty();
    test_fade_up();
    test_back_to_back();
    test_reverse();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
